io_bus_bridge: RTL

- Parametrised, single-clock successor to the processor-to-I/O-block interface.
- Decodes a processor word address into a one-hot block select and a register offset, and drives single-beat read/write strobes to the I/O blocks.
- Supports per-block wait states through a Ready handshake, a registered read-data return, and an error response for unmapped blocks.
- Sits between the processor load/store stage and the peripheral register blocks.

---
 rtl/io_bus_bridge_pkg.sv | 30 +++
 rtl/io_bus_bridge_if.sv | 41 ++++
 rtl/io_bus_bridge_timeout.sv | 32 +++
 rtl/io_bus_bridge.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/io_bus_bridge_pkg.sv
// Shared types and defaults for the processor-to-I/O-block bridge.
package io_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } kind_t;

  localparam int DEF_DW         = 32;
  localparam int DEF_AW         = 30;
  localparam int DEF_REG_AW     = 4;
  localparam int DEF_NUM_BLOCKS = 8;
  localparam int DEF_TIMEOUT    = 15;
  localparam int MAX_BLOCKS     = 16;

  // One-hot select for a block index; all zeros when the index is unmapped.
  function automatic logic [MAX_BLOCKS-1:0] onehot_sel(input logic [3:0] index,
                                                       input int num_blocks);
    logic [MAX_BLOCKS-1:0] sel;
    sel = '0;
    if (int'(index) < num_blocks) sel[index] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/io_bus_bridge_if.sv
// Processor-side request/response and block-side strobe signals of the bridge.
// master: the bridge itself; slave: the processor plus the I/O blocks.
interface io_bus_bridge_if
  import io_bus_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int REG_AW     = DEF_REG_AW
) ();

  logic [AW-1:0]         Sys_Address;
  logic [DW-1:0]         Sys_WrData;
  logic                  Sys_WrEn;
  logic                  Sys_RdEn;
  logic                  Sys_Busy;
  logic                  Sys_Done;
  logic                  Sys_Error;
  logic [DW-1:0]         Sys_RdData;
  logic                  Sys_RdValid;
  logic [NUM_BLOCKS-1:0] Blk_Select;
  logic [REG_AW-1:0]     Blk_RegAddress;
  logic [DW-1:0]         Blk_WrData;
  logic                  Blk_WrEn;
  logic                  Blk_RdEn;
  logic [DW-1:0]         Blk_RdData [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] Blk_Ready;

  modport master (
    input  Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, Blk_RdData, Blk_Ready,
    output Sys_Busy, Sys_Done, Sys_Error, Sys_RdData, Sys_RdValid,
           Blk_Select, Blk_RegAddress, Blk_WrData, Blk_WrEn, Blk_RdEn
  );

  modport slave (
    output Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, Blk_RdData, Blk_Ready,
    input  Sys_Busy, Sys_Done, Sys_Error, Sys_RdData, Sys_RdValid,
           Blk_Select, Blk_RegAddress, Blk_WrData, Blk_WrEn, Blk_RdEn
  );

endinterface

// File: rtl/io_bus_bridge_timeout.sv
// Wait-state counter for the bridge; flags expiry when the selected block
// has not answered within TIMEOUT_CYCLES wait cycles.
module io_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Clear on access entry, count each access cycle that ends without Ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (active && !ready && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Ready in the limit cycle takes priority over expiry.
  assign expired = active && !ready && (cnt_q == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/io_bus_bridge.sv
// Processor-to-I/O-block bridge: decodes a word address into a one-hot block
// select plus register offset and runs one single-beat access at a time.
// Optional wait timeout: define IO_BUS_BRIDGE_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | no access in flight; requests sampled, errors answered directly
//   ACCESS | strobes driven from captured request until selected Ready
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int DW             = DEF_DW,
  parameter int AW             = DEF_AW,
  parameter int NUM_BLOCKS     = DEF_NUM_BLOCKS,
  parameter int REG_AW         = DEF_REG_AW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst_n,
  io_bus_bridge_if.master bus
);

  localparam int BAW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  state_t                state_q, state_d;
  kind_t                 kind_q;
  logic [BAW-1:0]        idx_q;
  logic [REG_AW-1:0]     off_q;
  logic [DW-1:0]         wdata_q;
  logic [DW-1:0]         rdata_q;
  logic                  done_q, err_q;
  logic                  done_d, err_d, capture;
  logic [BAW-1:0]        idx_in;
  logic                  mapped, in_access, ready_sel, expired;
  logic [MAX_BLOCKS-1:0] sel_full;
  logic [NUM_BLOCKS-1:0] blk_sel;
  logic [DW-1:0]         rd_mux;

  assign idx_in    = bus.Sys_Address[REG_AW +: BAW];
  assign mapped    = int'(idx_in) < NUM_BLOCKS;
  assign in_access = (state_q == ACCESS);
  assign sel_full  = onehot_sel(4'(idx_q), NUM_BLOCKS);
  assign blk_sel   = sel_full[NUM_BLOCKS-1:0];
  assign ready_sel = |(bus.Blk_Ready & blk_sel);

  if (NUM_BLOCKS < MAX_BLOCKS) begin : g_sel_hi
    logic unused_sel_hi;
    assign unused_sel_hi = |sel_full[MAX_BLOCKS-1:NUM_BLOCKS];
  end

  if (AW > REG_AW + BAW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.Sys_Address[AW-1:REG_AW+BAW];
  end

  // Read-data mux over the captured block select.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (blk_sel[i]) rd_mux = bus.Blk_RdData[i];
    end
  end

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
  logic enter_access;
  assign enter_access = (state_q == IDLE) && (state_d == ACCESS);

  io_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (enter_access),
    .active (in_access),
    .ready  (ready_sel),
    .expired(expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  // Next-state and completion decode.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Sys_WrEn || bus.Sys_RdEn) begin
          capture = 1'b1;
          if (mapped && !(bus.Sys_WrEn && bus.Sys_RdEn)) begin
            state_d = ACCESS;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request capture, completion flags and read-data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= ACC_RD;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (capture) begin
        kind_q  <= bus.Sys_WrEn ? ACC_WR : ACC_RD;
        idx_q   <= idx_in;
        off_q   <= bus.Sys_Address[REG_AW-1:0];
        wdata_q <= bus.Sys_WrData;
      end
      if (in_access && ready_sel && (kind_q == ACC_RD)) rdata_q <= rd_mux;
    end
  end

  assign bus.Sys_Busy       = in_access;
  assign bus.Sys_Done       = done_q;
  assign bus.Sys_Error      = err_q;
  assign bus.Sys_RdData     = rdata_q;
  assign bus.Sys_RdValid    = done_q && !err_q && (kind_q == ACC_RD);
  assign bus.Blk_Select     = in_access ? blk_sel : '0;
  assign bus.Blk_RegAddress = in_access ? off_q : '0;
  assign bus.Blk_WrData     = in_access ? wdata_q : '0;
  assign bus.Blk_WrEn       = in_access && (kind_q == ACC_WR);
  assign bus.Blk_RdEn       = in_access && (kind_q == ACC_RD);

endmodule
